// File: rtl/regfile_pkg.sv
// Shared types and constants for the IIC burst register file.
// Access type per register is resolved at elaboration from the RO/W1C masks.
package regfile_pkg;

  localparam logic [5:0]  DEF_BASE_ADDR = 6'h30;
  localparam logic [63:0] OOR_READ_VAL  = '1;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } accType_t;

  // RO wins when a register is flagged in both masks.
  function automatic accType_t accessType(input logic isRo, input logic isW1c);
    if (isRo)  return ACC_RO;
    if (isW1c) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/regfile_addr_ptr.sv
// Auto-incrementing address pointer with range check, wrap and sticky address error.
// Effective address is combinational; pointer and error update on the access edge.
module regfile_addr_ptr
  import regfile_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                IDX_W     = 2
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iAccess,
  input  logic [ADDR_W-1:0] ivAddress,
  output logic              oInRange,
  output logic [IDX_W-1:0]  ovIndex,
  output logic [ADDR_W-1:0] ovPointer,
  output logic              oAddrErr
);

  localparam logic [ADDR_W:0]   LAST_EXT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LAST     = LAST_EXT[ADDR_W-1:0];

  logic [ADDR_W-1:0] effAddr;

  assign effAddr  = (iStart && iAccess) ? ivAddress : ovPointer;
  assign oInRange = (effAddr >= BASE_ADDR) && ({1'b0, effAddr} <= LAST_EXT);
  assign ovIndex  = IDX_W'(effAddr - BASE_ADDR);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      ovPointer <= BASE_ADDR;
      oAddrErr  <= 1'b0;
    end else if (iAccess) begin
      if (oInRange) begin
        ovPointer <= (effAddr == LAST) ? BASE_ADDR : effAddr + 1'b1;
        if (iStart) oAddrErr <= 1'b0;
      end else begin
        // Park on the bad address so the master can see where it went wrong.
        ovPointer <= effAddr;
        oAddrErr  <= 1'b1;
      end
    end else if (iStart) begin
      ovPointer <= ivAddress;
      oAddrErr  <= 1'b0;
    end
  end

endmodule

// File: rtl/cont_read_seq_write_regfile.sv
// NUM_REGS-deep IIC register file with burst pointer, RO status and W1C sticky registers.
// Read data 1 cycle after the access cycle, done pulse 2 cycles after; no backpressure.
module cont_read_seq_write_regfile
  import regfile_pkg::*;
#(
  parameter int                         ADDR_W    = 6,
  parameter int                         DATA_W    = 8,
  parameter int                         NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0]          BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]        W1C_MASK  = '0
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iRnW,
  input  logic                         iEnable,
  input  logic                         iStart,
  input  logic [ADDR_W-1:0]            ivAddress,
  input  logic [DATA_W-1:0]            ivD,
  input  logic [NUM_REGS*DATA_W-1:0]   ivStatus,
  output logic [NUM_REGS*DATA_W-1:0]   ovRegs,
  output logic [DATA_W-1:0]            ovQ,
  output logic [ADDR_W-1:0]            ovPointer,
  output logic                         oAccessDone,
  output logic                         oAddrErr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic             enableQ;
  logic             doneP1;
  logic             accessCycle;
  logic             inRange;
  logic [IDX_W-1:0] regIdx;

  assign accessCycle = iEnable & ~enableQ;

  regfile_addr_ptr #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) uAddrPtr (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iAccess   (accessCycle),
    .ivAddress (ivAddress),
    .oInRange  (inRange),
    .ovIndex   (regIdx),
    .ovPointer (ovPointer),
    .oAddrErr  (oAddrErr)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      enableQ     <= 1'b0;
      doneP1      <= 1'b0;
      oAccessDone <= 1'b0;
    end else begin
      enableQ     <= iEnable;
      doneP1      <= accessCycle;
      oAccessDone <= doneP1;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      ovQ <= '0;
    end else if (accessCycle && iRnW) begin
      ovQ <= inRange ? ovRegs[regIdx*DATA_W +: DATA_W] : OOR_READ_VAL[DATA_W-1:0];
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
    localparam accType_t ACC = accessType(RO_MASK[i], W1C_MASK[i]);

    logic [DATA_W-1:0] regQ;
    logic [DATA_W-1:0] stat;
    logic              wrHit;

    assign stat  = ivStatus[i*DATA_W +: DATA_W];
    assign wrHit = accessCycle && !iRnW && inRange && (regIdx == IDX_W'(i));

    // A hardware set in the same cycle as a W1C clear keeps the bit set.
    always_ff @(posedge iClk) begin
      if (!iRst_n) begin
        regQ <= RESET_VAL[i*DATA_W +: DATA_W];
      end else begin
        case (ACC)
          ACC_RO:  regQ <= stat;
          ACC_W1C: regQ <= wrHit ? ((regQ & ~ivD) | stat) : (regQ | stat);
          default: if (wrHit) regQ <= ivD;
        endcase
      end
    end

    assign ovRegs[i*DATA_W +: DATA_W] = regQ;
  end

endmodule

// File: tb/tb_cont_read_seq_write_regfile.sv
// Directed and randomized bench for cont_read_seq_write_regfile against a per-cycle reference model.
// Register 0 is read-only status, register 1 is write-1-to-clear, registers 2-3 are read/write.
module tb_cont_read_seq_write_regfile;

  localparam int          NR      = 4;
  localparam logic [5:0]  BASE    = 6'h30;
  localparam logic [31:0] RST_VAL = 32'h00A5_0000;
  localparam logic [3:0]  ROM     = 4'b0001;
  localparam logic [3:0]  W1CM    = 4'b0010;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iRnW = 1'b0;
  logic        iEnable = 1'b0;
  logic        iStart = 1'b0;
  logic [5:0]  ivAddress = '0;
  logic [7:0]  ivD = '0;
  logic [31:0] ivStatus = '0;
  logic [31:0] ovRegs;
  logic [7:0]  ovQ;
  logic [5:0]  ovPointer;
  logic        oAccessDone;
  logic        oAddrErr;

  always #5 iClk = ~iClk;

  cont_read_seq_write_regfile #(
    .ADDR_W    (6),
    .DATA_W    (8),
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE),
    .RESET_VAL (RST_VAL),
    .RO_MASK   (ROM),
    .W1C_MASK  (W1CM)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iRnW        (iRnW),
    .iEnable     (iEnable),
    .iStart      (iStart),
    .ivAddress   (ivAddress),
    .ivD         (ivD),
    .ivStatus    (ivStatus),
    .ovRegs      (ovRegs),
    .ovQ         (ovQ),
    .ovPointer   (ovPointer),
    .oAccessDone (oAccessDone),
    .oAddrErr    (oAddrErr)
  );

  int nCheck = 0;
  int nPass = 0;
  int cyc = 0;
  int doneSeen = 0;

  logic [7:0] mRegs [NR];
  logic [7:0] mQ = '0;
  logic [5:0] mPtr = BASE;
  logic       mErr = 1'b0;
  logic       mPrevEn = 1'b0;
  logic       mDone = 1'b0;
  int         doneQ [$];

  logic [7:0] expRd [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] st(input int i);
    return ivStatus[i*8 +: 8];
  endfunction

  function automatic logic [31:0] packRegs();
    return {mRegs[3], mRegs[2], mRegs[1], mRegs[0]};
  endfunction

  // Applies the register-file rules for the clock edge that ends the current cycle.
  task automatic modelEdge();
    logic [7:0] nr [NR];
    logic       acc;
    logic [5:0] a;
    int         ai;
    int         idx;
    if (!iRst_n) begin
      for (int i = 0; i < NR; i++) mRegs[i] = RST_VAL[i*8 +: 8];
      mQ = '0;
      mPtr = BASE;
      mErr = 1'b0;
      mPrevEn = 1'b0;
      doneQ.delete();
      return;
    end
    acc = iEnable && !mPrevEn;
    for (int i = 0; i < NR; i++) begin
      if (ROM[i])       nr[i] = st(i);
      else if (W1CM[i]) nr[i] = mRegs[i] | st(i);
      else              nr[i] = mRegs[i];
    end
    a  = (iStart && acc) ? ivAddress : mPtr;
    ai = int'(a);
    if (acc) begin
      doneQ.push_back(cyc + 2);
      if (ai >= int'(BASE) && ai < int'(BASE) + NR) begin
        idx = ai - int'(BASE);
        if (iRnW) begin
          mQ = mRegs[idx];
        end else if (!ROM[idx]) begin
          if (W1CM[idx]) nr[idx] = (mRegs[idx] & ~ivD) | st(idx);
          else           nr[idx] = ivD;
        end
        mPtr = (idx == NR - 1) ? BASE : a + 6'd1;
        if (iStart) mErr = 1'b0;
      end else begin
        if (iRnW) mQ = 8'hFF;
        mErr = 1'b1;
        mPtr = a;
      end
    end else if (iStart) begin
      mPtr = ivAddress;
      mErr = 1'b0;
    end
    for (int i = 0; i < NR; i++) mRegs[i] = nr[i];
    mPrevEn = iEnable;
  endtask

  task automatic step();
    modelEdge();
    @(posedge iClk);
    #1;
    cyc++;
    mDone = (doneQ.size() > 0 && doneQ[0] == cyc);
    if (mDone) void'(doneQ.pop_front());
    if (oAccessDone) doneSeen++;
    chk("regs", ovRegs, packRegs());
    chk("q", {24'h0, ovQ}, {24'h0, mQ});
    chk("ptr", {26'h0, ovPointer}, {26'h0, mPtr});
    chk("done", {31'h0, oAccessDone}, {31'h0, mDone});
    chk("err", {31'h0, oAddrErr}, {31'h0, mErr});
  endtask

  task automatic access(input logic rnw, input logic start, input logic [5:0] addr, input logic [7:0] d);
    iEnable = 1'b1;
    iRnW = rnw;
    iStart = start;
    ivAddress = addr;
    ivD = d;
    step();
    iEnable = 1'b0;
    iStart = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] snap;
    int          d0;

    step();
    step();
    chk("rst_regs", ovRegs, RST_VAL);
    chk("rst_q", {24'h0, ovQ}, 32'h0);
    chk("rst_ptr", {26'h0, ovPointer}, {26'h0, BASE});
    chk("rst_err", {31'h0, oAddrErr}, 32'h0);
    chk("rst_done", {31'h0, oAccessDone}, 32'h0);
    iRst_n = 1'b1;
    step();

    // Burst read of the reset image
    iStart = 1'b1;
    ivAddress = 6'h30;
    step();
    iStart = 1'b0;
    d0 = doneSeen;
    for (int k = 0; k < 4; k++) begin
      access(1'b1, 1'b0, 6'h00, 8'h00);
      chk("burst_rd", {24'h0, ovQ}, {24'h0, expRd[k]});
    end
    step();
    chk("burst_rd_done_cnt", doneSeen - d0, 32'd4);
    chk("burst_rd_wrap", {26'h0, ovPointer}, 32'h30);

    // Burst write
    access(1'b0, 1'b1, 6'h32, 8'h11);
    access(1'b0, 1'b0, 6'h00, 8'h22);
    chk("bw_reg2", {24'h0, ovRegs[23:16]}, 32'h11);
    chk("bw_reg3", {24'h0, ovRegs[31:24]}, 32'h22);
    chk("bw_ptr", {26'h0, ovPointer}, 32'h30);

    // RO and W1C behaviour
    ivStatus = 32'h0000_005A;
    step();
    ivStatus = 32'h0000_085A;
    step();
    ivStatus = 32'h0000_005A;
    step();
    chk("ro_reg0", {24'h0, ovRegs[7:0]}, 32'h5A);
    chk("w1c_set", {24'h0, ovRegs[15:8]}, 32'h08);
    access(1'b0, 1'b1, 6'h30, 8'hFF);
    chk("ro_wr_ignored", {24'h0, ovRegs[7:0]}, 32'h5A);
    access(1'b0, 1'b0, 6'h00, 8'h08);
    chk("w1c_clear", {24'h0, ovRegs[15:8]}, 32'h00);
    ivStatus = 32'h0000_085A;
    step();
    access(1'b0, 1'b1, 6'h31, 8'h08);
    chk("w1c_set_wins", {24'h0, ovRegs[15:8]}, 32'h08);
    ivStatus = 32'h0000_005A;
    access(1'b0, 1'b1, 6'h31, 8'h08);
    chk("w1c_clear2", {24'h0, ovRegs[15:8]}, 32'h00);

    // Out of range
    iStart = 1'b1;
    ivAddress = 6'h10;
    step();
    iStart = 1'b0;
    snap = ovRegs;
    access(1'b1, 1'b0, 6'h00, 8'h00);
    chk("oor_q", {24'h0, ovQ}, 32'hFF);
    chk("oor_err", {31'h0, oAddrErr}, 32'h1);
    access(1'b0, 1'b0, 6'h00, 8'h77);
    chk("oor_no_write", ovRegs, snap);
    chk("oor_ptr_hold", {26'h0, ovPointer}, 32'h10);
    step();
    chk("oor_err_sticky", {31'h0, oAddrErr}, 32'h1);
    iStart = 1'b1;
    ivAddress = 6'h30;
    step();
    iStart = 1'b0;
    chk("oor_err_clear", {31'h0, oAddrErr}, 32'h0);

    // Held enable gives one access
    iStart = 1'b1;
    ivAddress = 6'h32;
    step();
    iStart = 1'b0;
    d0 = doneSeen;
    iEnable = 1'b1;
    iRnW = 1'b0;
    ivD = 8'h3C;
    repeat (10) step();
    iEnable = 1'b0;
    repeat (3) step();
    chk("held_wr", {24'h0, ovRegs[23:16]}, 32'h3C);
    chk("held_ptr", {26'h0, ovPointer}, 32'h33);
    chk("held_done_cnt", doneSeen - d0, 32'd1);

    // Reset one cycle after an access edge
    iEnable = 1'b1;
    iRnW = 1'b1;
    iStart = 1'b1;
    ivAddress = 6'h32;
    step();
    iEnable = 1'b0;
    iStart = 1'b0;
    iRst_n = 1'b0;
    d0 = doneSeen;
    step();
    chk("mid_rst_regs", ovRegs, RST_VAL);
    chk("mid_rst_q", {24'h0, ovQ}, 32'h0);
    chk("mid_rst_ptr", {26'h0, ovPointer}, 32'h30);
    chk("mid_rst_err", {31'h0, oAddrErr}, 32'h0);
    iRst_n = 1'b1;
    repeat (3) step();
    chk("mid_rst_no_done", doneSeen - d0, 32'd0);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 300; n++) begin
      ivStatus = {16'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom)};
      if ($urandom_range(0, 99) == 0) begin
        iRst_n = 1'b0;
        step();
        iRst_n = 1'b1;
      end
      access(1'($urandom), ($urandom_range(0, 3) == 0), 6'($urandom_range(46, 53)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end
    repeat (3) step();

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
